// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: FSM state, write-back source encodings,
// register index width.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } pipe_state_t;

    // Write-back source select (wD_sel)
    localparam logic [1:0] WD_ALU  = 2'b00;
    localparam logic [1:0] WD_DRAM = 2'b01;
    localparam logic [1:0] WD_PC4  = 2'b10;
    localparam logic [1:0] WD_IMM  = 2'b11;

    localparam int REG_AW = 5;

endpackage

// File: rtl/hazard_detect.sv
// Load-use compare: a load in EX whose destination is read by the ID
// instruction. Purely combinational; shared with the forwarding unit.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_re1,
    input  logic              id_re2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_RegWrite,
    input  logic [1:0]        ex_wD_sel,
    input  logic              ex_bubble,
    output logic              lu
);

    logic ex_load;
    logic src_hit;

    // x0 is never a real dependency, and a bubble carries no load
    assign ex_load = (ex_wD_sel == WD_DRAM) & ex_RegWrite & ~ex_bubble &
                     (ex_rd != '0);
    assign src_hit = (id_re1 & (id_rs1 == ex_rd)) |
                     (id_re2 & (id_rs2 == ex_rd));
    assign lu      = ex_load & src_hit;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stall/flush/bubble control for load-use hazards,
// EX-resolved branches and a ready-handshake data memory with timeout.
// Optional build macro: PIPE_HAZARD_CTRL_PERF_EN compiles in the
// saturating performance counters; otherwise the counter ports read 0.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_re1,
    input  logic              id_re2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_RegWrite,
    input  logic [1:0]        ex_wD_sel,
    input  logic              ex_bubble,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              idex_stall,
    output logic              exmem_stall,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              memwb_bubble,
    output logic              mem_err,
    output logic [CNT_W-1:0]  lu_cnt,
    output logic [CNT_W-1:0]  mem_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    pipe_state_t       state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_hold;
    logic              lu;

    assign mem_hold = mem_req & ~mem_ready;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_re1      (id_re1),
        .id_re2      (id_re2),
        .ex_rd       (ex_rd),
        .ex_RegWrite (ex_RegWrite),
        .ex_wD_sel   (ex_wD_sel),
        .ex_bubble   (ex_bubble),
        .lu          (lu)
    );

    // Memory-wait FSM with timeout counter; MEM_ERR is left only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_hold) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!mem_hold) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                        state   <= MEM_ERR;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                MEM_ERR: begin
                    state <= MEM_ERR;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Mealy control outputs: memory hold beats branch beats load-use
    always_comb begin
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        idex_stall   = 1'b0;
        exmem_stall  = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        memwb_bubble = 1'b0;
        if (!reset) begin
            if (state == MEM_ERR || mem_hold) begin
                // Whole pipe frozen; a taken branch stays in EX and is
                // seen again on the release cycle
                pc_stall     = 1'b1;
                ifid_stall   = 1'b1;
                idex_stall   = 1'b1;
                exmem_stall  = 1'b1;
                memwb_bubble = 1'b1;
            end else if (ex_branch_taken) begin
                // ID holds a wrong-path instruction, so any lu is moot
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (lu) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
            end
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic lu_ev;
    logic mem_ev;
    logic fl_ev;

    assign mem_ev = (state != MEM_ERR) & mem_hold;
    assign fl_ev  = (state != MEM_ERR) & ~mem_hold & ex_branch_taken;
    assign lu_ev  = (state != MEM_ERR) & ~mem_hold & ~ex_branch_taken & lu;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            lu_cnt    <= '0;
            mem_cnt   <= '0;
            flush_cnt <= '0;
        end else begin
            if (lu_ev && lu_cnt != '1)
                lu_cnt <= lu_cnt + 1'b1;
            if (mem_ev && mem_cnt != '1)
                mem_cnt <= mem_cnt + 1'b1;
            if (fl_ev && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`else
    assign lu_cnt    = '0;
    assign mem_cnt   = '0;
    assign flush_cnt = '0;
`endif

endmodule
